// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer register file and the blocks that sit
// on its ports.
//   XLEN        : width of one integer register
//   REG_ADDR_W  : width of a register index
//   NUM_REGS    : number of architectural integer registers
//   dump_state_t: state encoding of the register-file dump reader
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Debug readout master on a spare read port of the integer register file.
// Reads either one selected register or an ascending sweep FIRST_REG..LAST_REG
// and streams each captured word out over a valid/ready interface.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : request a readout (sampled only in IDLE)
//   mode_single   : with start: 1 = read req_addr only, 0 = full sweep
//   req_addr      : register index for single mode
//   abort         : synchronous cancel of a readout in progress
//   rf_addr       : register-file read address (always equals cur)
//   rf_data       : register-file read data, combinational from rf_addr
//   out_valid     : out_data / out_addr / out_last are valid
//   out_ready     : consumer accepts the current word
//   out_data      : captured register value (x0 always reads as zero)
//   out_addr      : register index the word came from
//   out_last      : final word of this readout
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode_single,
  input  logic [REG_ADDR_W-1:0] req_addr,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [XLEN-1:0]       rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  import riscv_pkg::dump_state_t, riscv_pkg::IDLE, riscv_pkg::READ,
         riscv_pkg::SEND, riscv_pkg::DONE;

  dump_state_t           state;
  logic [REG_ADDR_W-1:0] cur;   // register currently addressed
  logic [REG_ADDR_W-1:0] last;  // final register of this readout

  // The read port follows cur directly so rf_data is settled by the READ edge.
  assign rf_addr = cur;

  // NOTE: every register here is written with <= so all state updates see the
  // values from before the edge; a blocking '=' would let later statements in
  // this block observe half-updated state and break the FSM ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Abort wins over a same-cycle handshake: that word is dropped.
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_single) begin
              cur  <= req_addr;
              last <= req_addr;
            end else begin
              cur  <= REG_ADDR_W'(FIRST_REG);
              last <= REG_ADDR_W'(LAST_REG);
            end
            busy  <= 1'b1;
            state <= READ;
          end
        end

        READ: begin
          // x0 is hardwired to zero regardless of what the array holds.
          out_data  <= (cur == '0) ? '0 : rf_data;
          out_addr  <= cur;
          out_last  <= (cur == last);
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // No wrap check needed: the sweep stops at last <= max index.
              cur   <= cur + 1'b1;
              state <= READ;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Directed bench for regfile_dump_reader with a behavioural register file
// (combinational read, clocked write) and hand-computed expected words.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode_single;
  logic [4:0]  req_addr;
  logic        abort;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  // Register file model: combinational read, write lands on the clock edge.
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rf [32];

  assign rf_data = rf[rf_addr];

  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  logic [31:0] exp_mem [32];
  int          checks   = 0;
  int          failures = 0;
  bit          wr7_fired;

  always #5 clk = ~clk;

  regfile_dump_reader #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .FIRST_REG  (0),
    .LAST_REG   (31)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode_single (mode_single),
    .req_addr    (req_addr),
    .abort       (abort),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic preload_sweep();
    rf_write(5'd0, 32'hFFFF_FFFF);
    for (int i = 1; i < 32; i++) rf_write(5'(i), 32'h1000 + i);
    exp_mem[0] = 32'h0;
    for (int i = 1; i < 32; i++) exp_mem[i] = 32'h1000 + i;
  endtask

  // Issues start for one cycle; returns at the negedge after the sampling edge.
  task automatic start_readout(input logic single, input logic [4:0] a);
    @(negedge clk);
    start = 1'b1; mode_single = single; req_addr = a;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_busy got busy=%b out_valid=%b expected busy=1 out_valid=0", busy, out_valid);
    end
  endtask

  // Drives out_ready and checks every accepted word against exp_mem in
  // ascending order from first_addr. Returns on done, on reaching stop_after
  // accepted words with a word pending (ready held low), or on timeout.
  task automatic collect(input int ready_mode, input int stop_after,
                         input int start_pulse_word, input bit wr7,
                         input logic [4:0] first_addr, input logic [4:0] last_addr,
                         output int nwords, output int ncycles, output bit saw_done);
    logic [4:0]  exp_addr;
    logic [31:0] s_data;
    logic [4:0]  s_addr;
    logic        s_last;
    bit          hold;
    bit          fin;
    int          low_run;
    int          r;
    exp_addr = first_addr; hold = 0; fin = 0; low_run = 0;
    nwords = 0; ncycles = 0; saw_done = 0;
    s_data = '0; s_addr = '0; s_last = 1'b0;
    while (!fin && ncycles < 400) begin
      @(negedge clk);
      ncycles++;
      wr_en = 1'b0;
      start = 1'b0;
      if (done) begin
        saw_done = 1; fin = 1;
      end else if (stop_after >= 0 && nwords == stop_after && out_valid) begin
        out_ready = 1'b0; fin = 1;
      end else begin
        if (hold) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== s_data || out_addr !== s_addr || out_last !== s_last) begin
            failures++;
            $display("FAIL hold_stable got v=%b d=%h a=%0d l=%b expected v=1 d=%h a=%0d l=%b",
                     out_valid, out_data, out_addr, out_last, s_data, s_addr, s_last);
          end
        end
        if (ready_mode == 0) out_ready = 1'b1;
        else if (low_run > 0) begin out_ready = 1'b0; low_run--; end
        else begin
          r = $urandom_range(0, 5);
          if (r == 0) begin out_ready = 1'b0; low_run = 3; end
          else out_ready = (r > 2);
        end
        hold = 0;
        if (out_valid) begin
          if (out_ready) begin
            checks++;
            if (out_addr !== exp_addr || out_data !== exp_mem[exp_addr] ||
                out_last !== (exp_addr == last_addr)) begin
              failures++;
              $display("FAIL word got a=%0d d=%h l=%b expected a=%0d d=%h l=%b",
                       out_addr, out_data, out_last, exp_addr, exp_mem[exp_addr], (exp_addr == last_addr));
            end
            nwords++;
            exp_addr++;
          end else begin
            hold = 1; s_data = out_data; s_addr = out_addr; s_last = out_last;
          end
        end
        if (start_pulse_word >= 0 && nwords == start_pulse_word && busy) begin
          start = 1'b1; mode_single = 1'b1; req_addr = 5'd3;
          start_pulse_word = -1;
        end
        if (wr7 && busy && !out_valid && rf_addr == 5'd7) begin
          wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA_5555;
          wr7_fired = 1;
        end
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL collect_timeout got words=%0d expected completion within 400 cycles", nwords);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy !== 0 || out_valid !== 0 || out_data !== 0 || out_addr !== 0 ||
        out_last !== 0 || done !== 0 || rf_addr !== 0) begin
      failures++;
      $display("FAIL reset_state got busy=%b v=%b d=%h a=%0d l=%b done=%b rf_addr=%0d expected all 0",
               busy, out_valid, out_data, out_addr, out_last, done, rf_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, cyc; bit sd;
    rf_write(5'd5, 32'hDEAD_BEEF);
    exp_mem[5] = 32'hDEAD_BEEF;
    start_readout(1'b1, 5'd5);
    collect(0, -1, -1, 0, 5'd5, 5'd5, n, cyc, sd);
    checks++;
    if (n !== 1 || !sd || cyc !== 2) begin
      failures++;
      $display("FAIL single got words=%0d done=%b cycles=%0d expected 1 1 2", n, sd, cyc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_sweep();
    int n, cyc; bit sd;
    preload_sweep();
    start_readout(1'b0, 5'd0);
    collect(0, -1, -1, 0, 5'd0, 5'd31, n, cyc, sd);
    checks++;
    if (n !== 32 || !sd || cyc < 62 || cyc > 66) begin
      failures++;
      $display("FAIL sweep got words=%0d done=%b cycles=%0d expected 32 1 64+-2", n, sd, cyc);
    end
  endtask

  task automatic test_backpressure();
    int n, cyc; bit sd;
    start_readout(1'b0, 5'd0);
    collect(1, -1, -1, 0, 5'd0, 5'd31, n, cyc, sd);
    checks++;
    if (n !== 32 || !sd) begin
      failures++;
      $display("FAIL backpressure got words=%0d done=%b expected 32 1", n, sd);
    end
  endtask

  task automatic test_abort();
    int n, cyc; bit sd; bit bad_done;
    start_readout(1'b0, 5'd0);
    collect(0, 9, -1, 0, 5'd0, 5'd31, n, cyc, sd);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 0 || busy !== 0 || done !== 0 || out_last !== 0) begin
      failures++;
      $display("FAIL abort got v=%b busy=%b done=%b last=%b expected 0 0 0 0", out_valid, busy, done, out_last);
    end
    bad_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done = 1;
    end
    checks++;
    if (bad_done) begin
      failures++;
      $display("FAIL abort_no_done got done pulse expected none");
    end
    start_readout(1'b0, 5'd0);
    collect(0, -1, -1, 0, 5'd0, 5'd31, n, cyc, sd);
    checks++;
    if (n !== 32 || !sd) begin
      failures++;
      $display("FAIL after_abort got words=%0d done=%b expected 32 1", n, sd);
    end
  endtask

  task automatic test_write_race();
    int n, cyc; bit sd;
    wr7_fired = 0;
    start_readout(1'b0, 5'd0);
    collect(0, -1, -1, 1, 5'd0, 5'd31, n, cyc, sd);
    checks++;
    if (n !== 32 || !sd || !wr7_fired) begin
      failures++;
      $display("FAIL race_sweep got words=%0d done=%b wrote=%b expected 32 1 1", n, sd, wr7_fired);
    end
    exp_mem[7] = 32'hAAAA_5555;
    start_readout(1'b1, 5'd7);
    collect(0, -1, -1, 0, 5'd7, 5'd7, n, cyc, sd);
    checks++;
    if (n !== 1 || !sd) begin
      failures++;
      $display("FAIL race_reread got words=%0d done=%b expected 1 1", n, sd);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int n, cyc; bit sd; int waited;
    start_readout(1'b0, 5'd0);
    collect(0, -1, 5, 0, 5'd0, 5'd31, n, cyc, sd);
    checks++;
    if (n !== 32 || !sd) begin
      failures++;
      $display("FAIL start_ignored got words=%0d done=%b expected 32 1", n, sd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_not_queued got busy=%b expected 0", busy);
    end
    out_ready = 1'b0;
    start_readout(1'b0, 5'd0);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_send got out_valid=%b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || out_valid !== 0 || out_data !== 0 || out_addr !== 0 ||
        out_last !== 0 || done !== 0 || rf_addr !== 0) begin
      failures++;
      $display("FAIL async_reset got busy=%b v=%b d=%h a=%0d l=%b done=%b rf_addr=%0d expected all 0",
               busy, out_valid, out_data, out_addr, out_last, done, rf_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || out_valid !== 0) begin
      failures++;
      $display("FAIL post_reset got busy=%b done=%b v=%b expected 0 0 0", busy, done, out_valid);
    end
  endtask

  initial begin
    start = 1'b0; mode_single = 1'b0; req_addr = '0; abort = 1'b0;
    out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr7_fired = 0;
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_abort();
    test_write_race();
    test_start_ignored_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
